// File: rtl/car_pkg.sv
// Shared encodings for the line-follower car: steering states, motor direction codes
// and the state-to-drive mapping used by the motor PWM channels.
package car_pkg;

    localparam int unsigned DUTY_W = 16;

    typedef enum logic [2:0] {
        S_TL     = 3'd0,
        S_TR     = 3'd1,
        S_ST     = 3'd2,
        S_SL     = 3'd3,
        S_SR     = 3'd4,
        S_SEARCH = 3'd5,
        S_STOP   = 3'd6,
        S_HALT   = 3'd7
    } drive_state_e;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef struct packed {
        logic [1:0]        left_dir;
        logic [1:0]        right_dir;
        logic [DUTY_W-1:0] left_duty;
        logic [DUTY_W-1:0] right_duty;
    } drive_cmd_t;

    // Steering state to per-motor direction and duty; SEARCH pivots toward the last seen side.
    function automatic drive_cmd_t drive_map(input drive_state_e st, input logic search_left,
                                             input logic [DUTY_W-1:0] fast,
                                             input logic [DUTY_W-1:0] slow,
                                             input logic [DUTY_W-1:0] turn);
        drive_cmd_t c;
        c = '{left_dir: DIR_BRAKE, right_dir: DIR_BRAKE, left_duty: '0, right_duty: '0};
        case (st)
            S_ST:     c = '{left_dir: DIR_FWD, right_dir: DIR_FWD, left_duty: fast, right_duty: fast};
            S_TL:     c = '{left_dir: DIR_FWD, right_dir: DIR_FWD, left_duty: slow, right_duty: fast};
            S_TR:     c = '{left_dir: DIR_FWD, right_dir: DIR_FWD, left_duty: fast, right_duty: slow};
            S_SL:     c = '{left_dir: DIR_REV, right_dir: DIR_FWD, left_duty: turn, right_duty: turn};
            S_SR:     c = '{left_dir: DIR_FWD, right_dir: DIR_REV, left_duty: turn, right_duty: turn};
            S_SEARCH: begin
                if (search_left)
                    c = '{left_dir: DIR_REV, right_dir: DIR_FWD, left_duty: turn, right_duty: turn};
                else
                    c = '{left_dir: DIR_FWD, right_dir: DIR_REV, left_duty: turn, right_duty: turn};
            end
            default:  c = '{left_dir: DIR_BRAKE, right_dir: DIR_BRAKE, left_duty: '0, right_duty: '0};
        endcase
        return c;
    endfunction

    function automatic logic is_brake(input drive_state_e st);
        return (st == S_STOP) || (st == S_HALT);
    endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One motor channel: free-running PWM compare with duty/dir taken only at the period
// boundary, plus an immediate brake override.
module motor_pwm_chan
    import car_pkg::*;
#(
    parameter int unsigned PWM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       dir_req,
    input  logic [PWM_W-1:0] duty_req,
    input  logic             brake,
    output logic [1:0]       dir,
    output logic             pwm
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] cnt_nxt;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_nxt;
    logic [1:0]       dir_nxt;

    // Brake overrides at once; otherwise new settings land only when the counter wraps.
    always_comb begin
        cnt_nxt  = cnt + PWM_W'(1);
        duty_nxt = duty_q;
        dir_nxt  = dir;
        if (cnt_nxt == '0) begin
            duty_nxt = duty_req;
            dir_nxt  = dir_req;
        end
        if (brake) begin
            duty_nxt = '0;
            dir_nxt  = DIR_BRAKE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_q <= '0;
            dir    <= DIR_BRAKE;
            pwm    <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            duty_q <= duty_nxt;
            dir    <= dir_nxt;
            pwm    <= (cnt_nxt < duty_nxt);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower drive controller: sensor sync/filter, line classification, lost-line
// and obstacle recovery FSM, and two motor PWM channels.
module line_follow_ctrl
    import car_pkg::*;
#(
    parameter int unsigned N_SENS       = 3,
    parameter int unsigned SAMPLE_DIV   = 100000,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned SHARP_TH     = 1,
    parameter int unsigned LOST_HOLD    = 50,
    parameter int unsigned SEARCH_TO    = 2000,
    parameter int unsigned RESUME_TICKS = 200,
    parameter int unsigned PWM_W        = 10,
    parameter int unsigned DUTY_FAST    = 768,
    parameter int unsigned DUTY_SLOW    = 256,
    parameter int unsigned DUTY_TURN    = 640
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] sense,
    input  logic              obstacle,
    input  logic              stop_en,
    output logic [1:0]        left_dir,
    output logic [1:0]        right_dir,
    output logic              left_pwm,
    output logic              right_pwm,
    output logic [2:0]        state,
    output logic              lost
);

    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned FLT_W  = $clog2(FILTER_LEN + 2);
    localparam int unsigned RES_W  = $clog2(RESUME_TICKS + 2);
    localparam int unsigned HOLD_W = $clog2(LOST_HOLD + 2);
    localparam int unsigned SRCH_W = $clog2(SEARCH_TO + 2);
    localparam int unsigned IDX_W  = $clog2(N_SENS);
    localparam int          N_I    = int'(N_SENS);
    localparam int          SHARP_I = int'(SHARP_TH);

    logic [N_SENS-1:0] sense_m, sense_s;
    logic              obst_m, obst_s;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick_c;
    logic [N_SENS-1:0] cand, filt, filt_nxt;
    logic [FLT_W-1:0]  cand_cnt, cand_cnt_nxt;
    logic [RES_W-1:0]  clr_cnt, clr_cnt_d;
    logic [HOLD_W-1:0] lost_cnt, lost_cnt_d;
    logic [SRCH_W-1:0] search_cnt, search_cnt_d;
    drive_state_e      state_q, state_d, last_steer, last_steer_d, cls;
    logic              last_left, last_left_d, lost_d;
    int                hi, lo, diff;
    drive_cmd_t        cmd;

    // Two-flop synchronisers for the asynchronous tracker and obstacle levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_m <= '0;
            sense_s <= '0;
            obst_m  <= 1'b0;
            obst_s  <= 1'b0;
        end else begin
            sense_m <= sense;
            sense_s <= sense_m;
            obst_m  <= obstacle;
            obst_s  <= obst_m;
        end
    end

    assign tick_c = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Candidate vector must repeat on FILTER_LEN consecutive ticks before it is accepted.
    always_comb begin
        cand_cnt_nxt = FLT_W'(1);
        if (sense_s == cand)
            cand_cnt_nxt = (cand_cnt == FLT_W'(FILTER_LEN)) ? cand_cnt : cand_cnt + FLT_W'(1);
        filt_nxt = filt;
        if (tick_c && (cand_cnt_nxt >= FLT_W'(FILTER_LEN)))
            filt_nxt = sense_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            cand     <= '0;
            cand_cnt <= '0;
            filt     <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            filt    <= filt_nxt;
            if (tick_c) begin
                cand     <= sense_s;
                cand_cnt <= cand_cnt_nxt;
            end
        end
    end

    // Line position: centre offset of the outermost lit sensors, positive toward the left.
    always_comb begin
        hi = 0;
        lo = 0;
        for (int i = 0; i < N_I; i++)
            if (filt_nxt[i[IDX_W-1:0]]) hi = i;
        for (int i = N_I - 1; i >= 0; i--)
            if (filt_nxt[i[IDX_W-1:0]]) lo = i;
        diff = hi + lo - (N_I - 1);
        cls  = S_ST;
        if (diff > SHARP_I)       cls = S_SL;
        else if (diff > 0)        cls = S_TL;
        else if (diff < -SHARP_I) cls = S_SR;
        else if (diff < 0)        cls = S_TR;
    end

    always_comb begin
        state_d      = state_q;
        last_steer_d = last_steer;
        last_left_d  = last_left;
        lost_d       = lost;
        clr_cnt_d    = clr_cnt;
        lost_cnt_d   = lost_cnt;
        search_cnt_d = search_cnt;
        if (tick_c) begin
            lost_d = (filt_nxt == '0);
            if (state_q != S_HALT) begin
                if ((filt_nxt != '0) && (diff != 0))
                    last_left_d = (diff > 0);
                if (obst_s && stop_en) begin
                    state_d      = S_STOP;
                    clr_cnt_d    = '0;
                    lost_cnt_d   = '0;
                    search_cnt_d = '0;
                end else if ((state_q == S_STOP) &&
                             ((clr_cnt + RES_W'(1)) < RES_W'(RESUME_TICKS))) begin
                    clr_cnt_d = clr_cnt + RES_W'(1);
                end else begin
                    clr_cnt_d = '0;
                    if (filt_nxt != '0) begin
                        state_d      = cls;
                        lost_cnt_d   = '0;
                        search_cnt_d = '0;
                    end else if (state_q == S_SEARCH) begin
                        if ((search_cnt + SRCH_W'(1)) >= SRCH_W'(SEARCH_TO))
                            state_d = S_HALT;
                        else
                            search_cnt_d = search_cnt + SRCH_W'(1);
                    end else if (lost_cnt >= HOLD_W'(LOST_HOLD)) begin
                        state_d      = S_SEARCH;
                        search_cnt_d = '0;
                    end else begin
                        state_d    = last_steer;
                        lost_cnt_d = lost_cnt + HOLD_W'(1);
                    end
                end
            end
        end
        if (state_d inside {S_TL, S_TR, S_ST, S_SL, S_SR})
            last_steer_d = state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_STOP;
            last_steer <= S_ST;
            last_left  <= 1'b1;
            lost       <= 1'b0;
            clr_cnt    <= '0;
            lost_cnt   <= '0;
            search_cnt <= '0;
        end else begin
            state_q    <= state_d;
            last_steer <= last_steer_d;
            last_left  <= last_left_d;
            lost       <= lost_d;
            clr_cnt    <= clr_cnt_d;
            lost_cnt   <= lost_cnt_d;
            search_cnt <= search_cnt_d;
        end
    end

    assign state = state_q;

    // Drive request follows the decided state so a brake takes effect on the deciding clock.
    assign cmd = drive_map(state_d, last_left_d, DUTY_W'(DUTY_FAST), DUTY_W'(DUTY_SLOW),
                           DUTY_W'(DUTY_TURN));

    motor_pwm_chan #(.PWM_W(PWM_W)) u_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_req  (cmd.left_dir),
        .duty_req (PWM_W'(cmd.left_duty)),
        .brake    (is_brake(state_d)),
        .dir      (left_dir),
        .pwm      (left_pwm)
    );

    motor_pwm_chan #(.PWM_W(PWM_W)) u_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_req  (cmd.right_dir),
        .duty_req (PWM_W'(cmd.right_duty)),
        .brake    (is_brake(state_d)),
        .dir      (right_dir),
        .pwm      (right_pwm)
    );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: table of per-tick vectors on a 3-sensor and a 5-sensor
// instance, plus hand sequences for mid-period braking and asynchronous reset.
module tb_line_follow_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [2:0] sense_a;
    logic [4:0] sense_b;
    logic       obst, en;
    logic [1:0] ldir_a, rdir_a, ldir_b, rdir_b;
    logic       lpwm_a, rpwm_a, lpwm_b, rpwm_b, lost_a, lost_b;
    logic [2:0] st_a, st_b;

    line_follow_ctrl #(
        .N_SENS(3), .SAMPLE_DIV(4), .FILTER_LEN(2), .SHARP_TH(1), .LOST_HOLD(3),
        .SEARCH_TO(8), .RESUME_TICKS(2), .PWM_W(4), .DUTY_FAST(12), .DUTY_SLOW(4), .DUTY_TURN(10)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .sense(sense_a), .obstacle(obst), .stop_en(en),
        .left_dir(ldir_a), .right_dir(rdir_a), .left_pwm(lpwm_a), .right_pwm(rpwm_a),
        .state(st_a), .lost(lost_a)
    );

    line_follow_ctrl #(
        .N_SENS(5), .SAMPLE_DIV(4), .FILTER_LEN(2), .SHARP_TH(1), .LOST_HOLD(3),
        .SEARCH_TO(8), .RESUME_TICKS(2), .PWM_W(4), .DUTY_FAST(12), .DUTY_SLOW(4), .DUTY_TURN(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .sense(sense_b), .obstacle(obst), .stop_en(en),
        .left_dir(ldir_b), .right_dir(rdir_b), .left_pwm(lpwm_b), .right_pwm(rpwm_b),
        .state(st_b), .lost(lost_b)
    );

    typedef struct {
        logic       sel_b;
        logic [4:0] sense;
        logic       obst;
        logic       en;
        int         wait_t;
        logic [2:0] st;
        logic       lost;
        logic       chk_dir;
        logic [1:0] ld;
        logic [1:0] rd;
        logic       chk_pwm;
        int         lc;
        int         rc;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic vec_t mk(input logic b, input logic [4:0] s, input logic o, input logic e,
                                input int w, input logic [2:0] st, input logic lo,
                                input logic cd, input logic [1:0] ld, input logic [1:0] rd,
                                input logic cp, input int lc, input int rc);
        vec_t v;
        v.sel_b = b;  v.sense = s;  v.obst = o;  v.en = e;  v.wait_t = w;
        v.st = st;    v.lost = lo;  v.chk_dir = cd; v.ld = ld; v.rd = rd;
        v.chk_pwm = cp; v.lc = lc;  v.rc = rc;
        return v;
    endfunction

    // Counts high cycles of both A pwm outputs over one 16-cycle period (consumes 4 ticks).
    task automatic measure(input string tag, input int lexp, input int rexp);
        int lc = 0;
        int rc = 0;
        for (int k = 0; k < 16; k++) begin
            lc += int'(lpwm_a);
            rc += int'(rpwm_a);
            @(negedge clk);
        end
        check({tag, ".left_pwm_high"}, lc, lexp);
        check({tag, ".right_pwm_high"}, rc, rexp);
    endtask

    task automatic run(input int lo_i, input int hi_i);
        for (int i = lo_i; i < hi_i; i++) begin
            vec_t v;
            v    = vecs[i];
            obst = v.obst;
            en   = v.en;
            if (v.sel_b) sense_b = v.sense;
            else         sense_a = v.sense[2:0];
            repeat (4 * v.wait_t) @(negedge clk);
            check($sformatf("v%0d.state", i), int'(v.sel_b ? st_b : st_a), int'(v.st));
            check($sformatf("v%0d.lost", i), int'(v.sel_b ? lost_b : lost_a), int'(v.lost));
            if (v.chk_dir) begin
                check($sformatf("v%0d.left_dir", i), int'(v.sel_b ? ldir_b : ldir_a), int'(v.ld));
                check($sformatf("v%0d.right_dir", i), int'(v.sel_b ? rdir_b : rdir_a), int'(v.rd));
            end
            if (v.chk_pwm) measure($sformatf("v%0d", i), v.lc, v.rc);
        end
    endtask

    initial begin
        int p1, p2, p3, p4;
        rst_a = 1'b0; rst_b = 1'b0;
        sense_a = 3'b010; sense_b = 5'b00011; obst = 1'b0; en = 1'b1;

        // Phase 1: start-up, turns, lost-line hold/search/halt.
        vecs.push_back(mk(0, 5'b010, 0, 1, 1, 3'd6, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 1, 3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 2, 3'd2, 0, 1, 2'b10, 2'b10, 1, 12, 12));
        vecs.push_back(mk(0, 5'b110, 0, 1, 1, 3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b110, 0, 1, 1, 3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b110, 0, 1, 2, 3'd0, 0, 1, 2'b10, 2'b10, 1, 4, 12));
        vecs.push_back(mk(0, 5'b100, 0, 1, 1, 3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b100, 0, 1, 1, 3'd3, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b100, 0, 1, 2, 3'd3, 0, 1, 2'b01, 2'b10, 1, 10, 10));
        vecs.push_back(mk(0, 5'b000, 0, 1, 1, 3'd3, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 2, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 3, 3'd5, 1, 1, 2'b01, 2'b10, 1, 10, 10));
        vecs.push_back(mk(0, 5'b000, 0, 1, 0, 3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 1, 3'd7, 1, 1, 2'b11, 2'b11, 1, 0, 0));
        vecs.push_back(mk(0, 5'b010, 1, 1, 3, 3'd7, 0, 1, 2'b11, 2'b11, 0, 0, 0));
        p1 = vecs.size();
        // Phase 2a: start-up to straight.
        vecs.push_back(mk(0, 5'b010, 0, 1, 2, 3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 2, 3'd2, 0, 1, 2'b10, 2'b10, 0, 0, 0));
        p2 = vecs.size();
        // Phase 2b: resume hysteresis, stop disabled, STOP beats a line change, search right.
        vecs.push_back(mk(0, 5'b010, 1, 1, 1, 3'd6, 0, 1, 2'b11, 2'b11, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 1, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 0, 1, 1, 3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 1, 0, 1, 3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b010, 1, 0, 1, 3'd2, 0, 1, 2'b10, 2'b10, 0, 0, 0));
        vecs.push_back(mk(0, 5'b001, 1, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b001, 1, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b001, 0, 1, 1, 3'd6, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b001, 0, 1, 1, 3'd4, 0, 1, 2'b10, 2'b01, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 5, 3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 5'b000, 0, 1, 3, 3'd5, 1, 1, 2'b10, 2'b01, 0, 0, 0));
        p3 = vecs.size();
        // Phase 3: five-sensor classification.
        vecs.push_back(mk(1, 5'b00011, 0, 1, 1, 3'd6, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(1, 5'b00011, 0, 1, 1, 3'd4, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(1, 5'b00100, 0, 1, 1, 3'd4, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(1, 5'b00100, 0, 1, 1, 3'd2, 0, 1, 2'b10, 2'b10, 0, 0, 0));
        vecs.push_back(mk(1, 5'b11000, 0, 1, 2, 3'd3, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk(1, 5'b11111, 0, 1, 2, 3'd2, 0, 1, 2'b10, 2'b10, 0, 0, 0));
        p4 = vecs.size();

        repeat (3) @(negedge clk);
        check("reset.state", int'(st_a), 6);
        check("reset.lost", int'(lost_a), 0);
        check("reset.left_dir", int'(ldir_a), 3);
        check("reset.right_dir", int'(rdir_a), 3);
        check("reset.pwm", int'({lpwm_a, rpwm_a}), 0);
        rst_a = 1'b1;
        run(0, p1);

        @(negedge clk); rst_a = 1'b0;
        @(negedge clk); rst_a = 1'b1;
        run(p1, p2);

        // Obstacle mid-period: drive holds until the deciding tick, then brakes on that clock.
        obst = 1'b1;
        repeat (3) @(negedge clk);
        check("prebrake.left_dir", int'(ldir_a), 2);
        check("prebrake.left_pwm", int'(lpwm_a), 1);
        @(negedge clk);
        check("brake.state", int'(st_a), 6);
        check("brake.left_dir", int'(ldir_a), 3);
        check("brake.right_dir", int'(rdir_a), 3);
        check("brake.pwm", int'({lpwm_a, rpwm_a}), 0);
        run(p2, p3);

        // Asynchronous reset in the middle of a search period.
        repeat (6) @(negedge clk);
        check("presearch.pwm", int'({lpwm_a, rpwm_a}), 3);
        #2 rst_a = 1'b0;
        #1;
        check("async_rst.state", int'(st_a), 6);
        check("async_rst.lost", int'(lost_a), 0);
        check("async_rst.dir", int'({ldir_a, rdir_a}), 15);
        check("async_rst.pwm", int'({lpwm_a, rpwm_a}), 0);

        @(negedge clk);
        check("reset_b.state", int'(st_b), 6);
        rst_b = 1'b1;
        run(p3, p4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
